// File: rtl/fp_pkg.sv
// Shared FP32 divider definitions: data width, exception flag packing and
// the priority rule that reduces the divider's flags to at most one.
package fp_pkg;

    localparam int FP32_W = 32;

    // Bit order {nan, exp_ovf, zero} matches the divider's flag packing.
    typedef struct packed {
        logic nan;
        logic exp_ovf;
        logic zero;
    } fp_flags_t;

    // Keep only the highest-priority flag: nan > zero > exp_ovf.
    function automatic fp_flags_t fp_flags_norm(input fp_flags_t f);
        fp_flags_t r;
        r = '0;
        if (f.nan) begin
            r.nan = 1'b1;
        end else if (f.zero) begin
            r.zero = 1'b1;
        end else if (f.exp_ovf) begin
            r.exp_ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter. A clear wins over the held value but still
// counts an event that arrives in the same cycle.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] r_q;

    // Count events, hold at all-ones, restart on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= inc ? W'(1) : '0;
        end else if (inc && (r_q != MAX)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/fp_div_result_queue.sv
// Result queue behind the combinational FP32 divider. Buffers quotients with
// their normalised exception flags and keeps sticky flags plus saturating
// per-flag event counters for the status block.
//
// Handshake: a transfer happens on a side only in a cycle where both valid and
// ready are high at the rising edge. in_ready depends only on the registered
// count (never on out_ready), out_valid only on count; upstream holds its data
// while in_valid is high and in_ready is low.
module fp_div_result_queue
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FP32_W-1:0]        in_res,
    input  logic                     in_exp_ovf,
    input  logic                     in_nan,
    input  logic                     in_zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FP32_W-1:0]        out_res,
    output logic [2:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic [2:0]               sticky_flags,
    output logic [CNT_W-1:0]         nan_cnt,
    output logic [CNT_W-1:0]         ovf_cnt,
    output logic [CNT_W-1:0]         zero_cnt,
    input  logic                     stat_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [FP32_W-1:0] r_mem_res   [DEPTH];
    fp_flags_t         r_mem_flags [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    fp_flags_t         r_sticky;

    logic      w_push;
    logic      w_pop;
    logic      w_empty;
    fp_flags_t w_in_flags;
    fp_flags_t w_norm_flags;
    fp_flags_t w_push_flags;

    assign w_empty      = (r_count == '0);
    assign in_ready     = (r_count != FULL_CNT);
    assign out_valid    = !w_empty;
    assign w_push       = in_valid & in_ready;
    assign w_pop        = out_valid & out_ready;

    assign w_in_flags   = '{nan: in_nan, exp_ovf: in_exp_ovf, zero: in_zero};
    assign w_norm_flags = fp_flags_norm(w_in_flags);
    assign w_push_flags = w_push ? w_norm_flags : '0;

    // Head is read straight from storage; zeroed so an empty queue shows no stale data.
    assign out_res      = w_empty ? '0 : r_mem_res[r_rd_ptr];
    assign out_flags    = w_empty ? '0 : r_mem_flags[r_rd_ptr];
    assign count        = r_count;
    assign sticky_flags = r_sticky;

    // Storage write on accepted push; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_res[r_wr_ptr]   <= in_res;
            r_mem_flags[r_wr_ptr] <= w_norm_flags;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a clear in the same cycle as a push keeps the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (stat_clr) begin
            r_sticky <= w_push_flags;
        end else begin
            r_sticky <= r_sticky | w_push_flags;
        end
    end

    sat_counter #(.W(CNT_W)) u_nan_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (w_push_flags.nan),
        .q     (nan_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (w_push_flags.exp_ovf),
        .q     (ovf_cnt)
    );

    sat_counter #(.W(CNT_W)) u_zero_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .inc   (w_push_flags.zero),
        .q     (zero_cnt)
    );

endmodule

// File: tb/tb_fp_div_result_queue.sv
// Directed bench for fp_div_result_queue (DEPTH=4, CNT_W=4 so saturation is reachable).
module tb_fp_div_result_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_res;
    logic        in_exp_ovf;
    logic        in_nan;
    logic        in_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic [2:0]  out_flags;
    logic [2:0]  count;
    logic [2:0]  sticky_flags;
    logic [CNT_W-1:0] nan_cnt;
    logic [CNT_W-1:0] ovf_cnt;
    logic [CNT_W-1:0] zero_cnt;
    logic        stat_clr;

    fp_div_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_res       (in_res),
        .in_exp_ovf   (in_exp_ovf),
        .in_nan       (in_nan),
        .in_zero      (in_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_flags    (out_flags),
        .count        (count),
        .sticky_flags (sticky_flags),
        .nan_cnt      (nan_cnt),
        .ovf_cnt      (ovf_cnt),
        .zero_cnt     (zero_cnt),
        .stat_clr     (stat_clr)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        in_valid   = 1'b0;
        in_res     = 32'h0;
        in_nan     = 1'b0;
        in_exp_ovf = 1'b0;
        in_zero    = 1'b0;
        out_ready  = 1'b0;
        stat_clr   = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] r, input logic n, input logic o, input logic z);
        in_valid   = 1'b1;
        in_res     = r;
        in_nan     = n;
        in_exp_ovf = o;
        in_zero    = z;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        v;
        logic [31:0] res;
        logic        nan;
        logic        ovf;
        logic        zero;
        logic        ordy;
        logic        clr;
        logic [2:0]  e_count;
        logic [31:0] e_res;
        logic [2:0]  e_flags;
        logic [2:0]  e_sticky;
        logic [3:0]  e_nan;
        logic [3:0]  e_ovf;
        logic [3:0]  e_zero;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        // inputs: v res nan ovf zero ordy clr | expected after edge
        vecs[0] = '{1'b1, 32'h3F800000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 32'h3F800000, 3'b100, 3'b100, 4'd1, 4'd0, 4'd0};
        vecs[1] = '{1'b1, 32'h40000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 32'h3F800000, 3'b100, 3'b101, 4'd1, 4'd0, 4'd1};
        vecs[2] = '{1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 32'h3F800000, 3'b100, 3'b111, 4'd1, 4'd1, 4'd1};
        vecs[3] = '{1'b1, 32'h7FC00000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 32'h40000000, 3'b001, 3'b111, 4'd2, 4'd1, 4'd1};
        vecs[4] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 32'h7F800000, 3'b010, 3'b111, 4'd2, 4'd1, 4'd1};
        vecs[5] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 32'h7FC00000, 3'b100, 3'b111, 4'd2, 4'd1, 4'd1};
        vecs[6] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h00000000, 3'b000, 3'b111, 4'd2, 4'd1, 4'd1};
        vecs[7] = '{1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 32'h7F800000, 3'b010, 3'b010, 4'd0, 4'd1, 4'd0};
        vecs[8] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 32'h7F800000, 3'b010, 3'b000, 4'd0, 4'd0, 4'd0};
        vecs[9] = '{1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h00000000, 3'b000, 3'b000, 4'd0, 4'd0, 4'd0};
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] fill_vals[4];
        logic [31:0] head;
        logic [31:0] v;
        fill_vals[0] = 32'h3F800000;
        fill_vals[1] = 32'h40000000;
        fill_vals[2] = 32'h40400000;
        fill_vals[3] = 32'h40800000;

        idle();
        rst_n = 1'b0;
        #1;
        chk("rst count",     32'(count),        32'd0);
        chk("rst in_ready",  32'(in_ready),     32'd1);
        chk("rst out_valid", 32'(out_valid),    32'd0);
        chk("rst out_res",   out_res,           32'd0);
        chk("rst out_flags", 32'(out_flags),    32'd0);
        chk("rst sticky",    32'(sticky_flags), 32'd0);
        chk("rst nan_cnt",   32'(nan_cnt),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table: flag normalisation, sticky, counters, simultaneous push/pop, clear collision.
        for (int i = 0; i < NV; i++) begin
            in_valid   = vecs[i].v;
            in_res     = vecs[i].res;
            in_nan     = vecs[i].nan;
            in_exp_ovf = vecs[i].ovf;
            in_zero    = vecs[i].zero;
            out_ready  = vecs[i].ordy;
            stat_clr   = vecs[i].clr;
            step();
            chk($sformatf("vec%0d count", i),     32'(count),        32'(vecs[i].e_count));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid),    32'(vecs[i].e_count != 3'd0));
            chk($sformatf("vec%0d in_ready", i),  32'(in_ready),     32'(vecs[i].e_count != 3'd4));
            chk($sformatf("vec%0d out_res", i),   out_res,           vecs[i].e_res);
            chk($sformatf("vec%0d out_flags", i), 32'(out_flags),    32'(vecs[i].e_flags));
            chk($sformatf("vec%0d sticky", i),    32'(sticky_flags), 32'(vecs[i].e_sticky));
            chk($sformatf("vec%0d nan_cnt", i),   32'(nan_cnt),      32'(vecs[i].e_nan));
            chk($sformatf("vec%0d ovf_cnt", i),   32'(ovf_cnt),      32'(vecs[i].e_ovf));
            chk($sformatf("vec%0d zero_cnt", i),  32'(zero_cnt),     32'(vecs[i].e_zero));
        end
        idle();

        // Fill to DEPTH with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            drive_push(fill_vals[i], 1'b0, 1'b0, 1'b0);
            exp_q.push_back(fill_vals[i]);
            step();
        end
        chk("fill count",    32'(count),    32'd4);
        chk("fill in_ready", 32'(in_ready), 32'd0);
        // Fifth push (flagged nan) must be ignored entirely, even with out_ready high.
        drive_push(32'h40A00000, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        chk("full pop count",    32'(count),    32'd3);
        chk("full no stat",      32'(nan_cnt),  32'd0);
        chk("full pop head",     out_res,       fill_vals[1]);
        void'(exp_q.pop_front());
        idle();
        // Head held stable while stalled.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall head", out_res, fill_vals[1]);
        end
        // Drain the remaining three in order.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("drain valid", 32'(out_valid), 32'd1);
            chk("drain data",  out_res,        exp_q.pop_front());
            step();
        end
        chk("drain empty", 32'(out_valid), 32'd0);
        chk("drain count", 32'(count),     32'd0);
        idle();

        // Mid-stream reset with flagged entries queued.
        drive_push(32'h7FC00000, 1'b1, 1'b0, 1'b0);
        step();
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst count",     32'(count),        32'd0);
        chk("mid rst out_valid", 32'(out_valid),    32'd0);
        chk("mid rst in_ready",  32'(in_ready),     32'd1);
        chk("mid rst out_res",   out_res,           32'd0);
        chk("mid rst sticky",    32'(sticky_flags), 32'd0);
        chk("mid rst nan_cnt",   32'(nan_cnt),      32'd0);
        step();
        rst_n = 1'b1;

        // Streaming: push and pop every cycle for 100 cycles.
        for (int i = 0; i < 100; i++) begin
            v = 32'h3F800000 + 32'(i);
            drive_push(v, 1'b0, 1'b0, 1'b0);
            out_ready = 1'b1;
            if (i == 0) begin
                chk("stream first empty", 32'(out_valid), 32'd0);
            end else begin
                head = exp_q.pop_front();
                chk($sformatf("stream data %0d", i), out_res, head);
            end
            exp_q.push_back(v);
            step();
            chk($sformatf("stream count %0d", i), 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        chk("stream last", out_res, exp_q.pop_front());
        step();
        chk("stream end empty", 32'(out_valid), 32'd0);
        idle();

        // Saturation: 20 nan pushes with the consumer draining.
        for (int i = 1; i <= 20; i++) begin
            drive_push(32'h7FC00000, 1'b1, 1'b0, 1'b0);
            out_ready = 1'b1;
            step();
            chk($sformatf("sat nan_cnt %0d", i), 32'(nan_cnt), (i > 15) ? 32'd15 : 32'(i));
        end
        idle();
        step();
        chk("sat hold",     32'(nan_cnt),      32'd15);
        chk("sat sticky",   32'(sticky_flags), 32'b100);
        chk("sat zero_cnt", 32'(zero_cnt),     32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
